ysyx_22050243_store_unit: RTL and testbench
===========================================

Name: ysyx_22050243_store_unit

Overview:
MEM-stage store path for the RV64 core, the write-side counterpart of the load extractor. Accepts one store request per transaction from the pipeline and decodes funct3 (SB/SH/SW/SD). Lane-aligns the data and builds the byte strobe, checks alignment, then drives a valid/ready write channel to data memory and waits for the write response. Reports completion, with an error flag, back to the pipeline, which stalls while busy.

Parameters:
WIDTH, 64, data and address width; only 64 is supported.
TIMEOUT, 256, cycles to wait for bus_bvalid before flagging an error; 0 disables the timeout.

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-high reset
req_valid  in  1  store request valid
req_ready  out  1  unit can accept a request
req_addr  in  WIDTH  byte address
req_funct3  in  3  000 SB, 001 SH, 010 SW, 011 SD
req_wdata  in  WIDTH  rs2 value, data in low bits
bus_wvalid  out  1  write request valid
bus_wready  in  1  memory accepts write
bus_waddr  out  WIDTH  req_addr with bits [2:0] cleared
bus_wdata  out  WIDTH  lane-shifted data
bus_wstrb  out  8  byte strobe
bus_bvalid  in  1  write response valid
bus_bresp  in  1  1 = bus error
done_valid  out  1  one-cycle completion pulse
done_err  out  1  error qualifier for done_valid
busy  out  1  high whenever state is not IDLE

Behaviour:
- Reset (async, any state): state=IDLE, timeout counter=0. All outputs 0 except req_ready=1. bus_wvalid drops immediately, even mid-handshake; any in-flight transaction is abandoned.
- FSM states: IDLE, WREQ, WRESP, DONE.
- IDLE: req_ready=1. On req_valid at a clock edge, register addr/data/strobe and compute the error.
  - Error -> DONE with err=1.
  - No error -> WREQ.
- Error conditions:
  - funct3 is not in 000..011.
  - Misaligned: SH with addr[0]!=0, SW with addr[1:0]!=0, SD with addr[2:0]!=0. SB is never misaligned.
  - An error issues no bus transaction.
- Strobe, with off=addr[2:0]:
  - SB: 8'h01<<off
  - SH: 8'h03<<off
  - SW: 8'h0F<<off
  - SD: 8'hFF
- bus_wdata = req_wdata << (8*off). Bits above the access size come from req_wdata and are don't-care because the strobe masks them.
- WREQ: bus_wvalid=1. Address, data and strobe stay stable until bus_wready is sampled high, then go to WRESP. bus_wvalid deasserts in the next cycle. The WREQ state has no timeout.
- WRESP: counter increments each cycle.
  - bus_bvalid -> DONE with err=bus_bresp; counter clears.
  - If TIMEOUT!=0 and the counter reaches TIMEOUT-1 without bvalid -> DONE with err=1.
  - If bvalid and timeout expiry occur in the same cycle, bvalid wins.
- DONE: done_valid=1 and done_err=err for exactly one cycle, then unconditionally -> IDLE.
- req_ready=0 in WREQ, WRESP and DONE. Requests presented there are not accepted, and the requester must hold them.
- bus_wready or bus_bvalid arriving outside their waiting state is ignored.
- Minimum latencies (accept edge = cycle 0):
  - Good store with immediate wready and bvalid: wvalid in cycle 1, bvalid sampled in cycle 2, done_valid in cycle 3, req_ready back in cycle 4.
  - Error store: done_valid in cycle 1.
- Outputs are registered or decoded from state only; no combinational path from req_* to bus_*.

Test Plan:
- SB: addr=0x8000_0003, wdata=0x..AB, wready and bvalid immediate -> bus_waddr=0x8000_0000, wstrb=0x08, wdata[31:24]=0xAB. done_valid in cycle 3 with done_err=0.
- SD: addr=0x8000_0010, wdata=0x1122334455667788 -> wstrb=0xFF, data unchanged. With wready delayed 5 cycles, wvalid stays high and stable for 6 cycles.
- Misaligned SW: addr=0x8000_0006 -> no bus_wvalid ever. done_valid=1 and done_err=1 in cycle 1. The same result applies for funct3=3'b100.
- Bus error: SH at addr=0x...2 with bresp=1 -> wstrb=0x0C, done_err=1.
- Timeout with TIMEOUT=4 and bvalid never asserted -> done_err=1 exactly 4 cycles after WRESP entry. Also bvalid on the last cycle -> done_err=bresp.
- Reset asserted mid-WREQ -> bus_wvalid=0 and req_ready=1 without a clock edge. A new SB is then accepted normally after reset releases.

Source files
------------

// File: rtl/ysyx_22050243_store_unit.sv
// ysyx_22050243_store_unit
// MEM-stage store path: decodes SB/SH/SW/SD, lane-aligns the store data,
// builds the byte strobe, rejects misaligned or unknown stores, and runs a
// single valid/ready write plus write-response exchange with data memory.
// Completion is reported as a one-cycle done pulse with an error qualifier.
// Only WIDTH=64 is meaningful: the lane math assumes an 8-byte bus.

module ysyx_22050243_store_unit #(
  parameter int WIDTH   = 64,
  parameter int TIMEOUT = 256
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [WIDTH-1:0] req_addr,
  input  logic [2:0]       req_funct3,
  input  logic [WIDTH-1:0] req_wdata,
  output logic             bus_wvalid,
  input  logic             bus_wready,
  output logic [WIDTH-1:0] bus_waddr,
  output logic [WIDTH-1:0] bus_wdata,
  output logic [7:0]       bus_wstrb,
  input  logic             bus_bvalid,
  input  logic             bus_bresp,
  output logic             done_valid,
  output logic             done_err,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WREQ  = 2'd1,
    WRESP = 2'd2,
    DONE  = 2'd3
  } state_t;

  // The counter only has to reach TIMEOUT-1; keep at least one bit so the
  // declaration stays legal when the timeout is disabled or tiny.
  localparam int          CW     = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam int          LAST_I = (TIMEOUT == 0) ? 0 : TIMEOUT - 1;
  localparam logic [CW-1:0] LAST = CW'(LAST_I);

  state_t state;
  state_t state_next;

  logic [2:0]       off;
  logic [7:0]       strb_dec;
  logic             err_dec;
  logic [WIDTH-1:0] wdata_dec;
  logic [WIDTH-1:0] waddr_dec;

  logic [WIDTH-1:0] waddr_q;
  logic [WIDTH-1:0] wdata_q;
  logic [7:0]       wstrb_q;
  logic             err_q;
  logic [CW-1:0]    cnt;
  logic             timeout_hit;

  assign off       = req_addr[2:0];
  assign waddr_dec = {req_addr[WIDTH-1:3], 3'b000};
  assign wdata_dec = req_wdata << {off, 3'b000};

  // Decode the access size into a strobe and flag unknown or misaligned stores.
  always_comb begin
    strb_dec = 8'h00;
    err_dec  = 1'b0;
    case (req_funct3)
      3'b000: begin
        strb_dec = 8'h01 << off;
      end
      3'b001: begin
        strb_dec = 8'h03 << off;
        err_dec  = off[0];
      end
      3'b010: begin
        strb_dec = 8'h0F << off;
        err_dec  = |off[1:0];
      end
      3'b011: begin
        strb_dec = 8'hFF;
        err_dec  = |off;
      end
      default: begin
        strb_dec = 8'h00;
        err_dec  = 1'b1;
      end
    endcase
  end

  // The response wait expires on the cycle the counter sits at TIMEOUT-1.
  assign timeout_hit = (TIMEOUT != 0) && (cnt == LAST);

  // State register; reset abandons any in-flight write immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic; bvalid is checked before the timeout so it wins a tie.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (req_valid) begin
          state_next = err_dec ? DONE : WREQ;
        end
      end
      WREQ: begin
        if (bus_wready) begin
          state_next = WRESP;
        end
      end
      WRESP: begin
        if (bus_bvalid || timeout_hit) begin
          state_next = DONE;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Capture the lane-aligned request on accept and track the response wait.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      waddr_q <= '0;
      wdata_q <= '0;
      wstrb_q <= 8'h00;
      err_q   <= 1'b0;
      cnt     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            waddr_q <= waddr_dec;
            wdata_q <= wdata_dec;
            wstrb_q <= strb_dec;
            err_q   <= err_dec;
            cnt     <= '0;
          end
        end
        WRESP: begin
          if (bus_bvalid) begin
            err_q <= bus_bresp;
            cnt   <= '0;
          end else if (timeout_hit) begin
            err_q <= 1'b1;
            cnt   <= '0;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: begin
          cnt <= '0;
        end
      endcase
    end
  end

  // Handshake outputs are decoded from state alone, so nothing on req_*
  // reaches the bus side combinationally.
  always_comb begin
    req_ready  = (state == IDLE);
    busy       = (state != IDLE);
    bus_wvalid = (state == WREQ);
    done_valid = (state == DONE);
    done_err   = (state == DONE) && err_q;
    bus_waddr  = waddr_q;
    bus_wdata  = wdata_q;
    bus_wstrb  = wstrb_q;
  end

endmodule

// File: tb/tb_ysyx_22050243_store_unit.sv
// tb_ysyx_22050243_store_unit
// Drives store transactions with directed and $urandom stimulus. Each
// transaction's strobe, lane data, error and per-cycle timing are predicted
// by a transaction-level model built from byte counts and offsets.

module tb_ysyx_22050243_store_unit;

  localparam int TO = 4;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [63:0] req_addr;
  logic [2:0]  req_funct3;
  logic [63:0] req_wdata;
  logic        bus_wvalid;
  logic        bus_wready;
  logic [63:0] bus_waddr;
  logic [63:0] bus_wdata;
  logic [7:0]  bus_wstrb;
  logic        bus_bvalid;
  logic        bus_bresp;
  logic        done_valid;
  logic        done_err;
  logic        busy;

  int n_checks;
  int n_fail;

  ysyx_22050243_store_unit #(
    .WIDTH   (64),
    .TIMEOUT (TO)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_addr   (req_addr),
    .req_funct3 (req_funct3),
    .req_wdata  (req_wdata),
    .bus_wvalid (bus_wvalid),
    .bus_wready (bus_wready),
    .bus_waddr  (bus_waddr),
    .bus_wdata  (bus_wdata),
    .bus_wstrb  (bus_wstrb),
    .bus_bvalid (bus_bvalid),
    .bus_bresp  (bus_bresp),
    .done_valid (done_valid),
    .done_err   (done_err),
    .busy       (busy)
  );

  // 10 ns clock; inputs change and outputs are sampled on the falling edge.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // One store transaction. wdelay = WREQ cycles before wready; bdelay = WRESP
  // cycle index carrying bvalid, or -1 for never. Called at a falling edge
  // with the DUT idle; returns at the falling edge of the first idle cycle.
  task automatic applyStimulus(input logic [63:0] addr, input logic [2:0] f3,
                               input logic [63:0] data, input int wdelay,
                               input int bdelay, input logic bresp);
    int          size;
    int          off;
    bit          err;
    bit          exp_err;
    bit          exp_wv;
    int          wresp_start;
    int          done_cyc;
    logic [7:0]  exp_strb;
    logic [63:0] exp_data;
    logic [63:0] mask;
    logic [63:0] exp_addr;

    off = int'(addr[2:0]);
    case (f3)
      3'd0:    size = 1;
      3'd1:    size = 2;
      3'd2:    size = 4;
      3'd3:    size = 8;
      default: size = 0;
    endcase
    err      = (size == 0) || ((off % size) != 0);
    exp_strb = 8'h00;
    exp_data = 64'h0;
    if (!err) begin
      for (int i = 0; i < size; i++) begin
        exp_strb[off + i]          = 1'b1;
        exp_data[8*(off + i) +: 8] = data[8*i +: 8];
      end
    end
    for (int i = 0; i < 8; i++) begin
      mask[8*i +: 8] = {8{exp_strb[i]}};
    end
    exp_addr = addr & ~64'h7;

    wresp_start = 2 + wdelay;
    if (err) begin
      done_cyc = 1;
      exp_err  = 1'b1;
    end else if (bdelay >= 0 && bdelay < TO) begin
      done_cyc = wresp_start + bdelay + 1;
      exp_err  = bresp;
    end else begin
      done_cyc = wresp_start + TO;
      exp_err  = 1'b1;
    end

    checkOutput("ready_before_req", 64'(req_ready), 64'(1'b1));
    req_addr   = addr;
    req_funct3 = f3;
    req_wdata  = data;
    req_valid  = 1'b1;
    @(posedge clk);
    @(negedge clk);

    for (int c = 1; c <= done_cyc + 1; c++) begin
      exp_wv = !err && (c <= 1 + wdelay);
      checkOutput("wvalid",    64'(bus_wvalid), 64'(exp_wv));
      checkOutput("done_valid", 64'(done_valid), 64'(c == done_cyc));
      checkOutput("done_err",  64'(done_err),  64'((c == done_cyc) && exp_err));
      checkOutput("req_ready", 64'(req_ready), 64'(c == done_cyc + 1));
      checkOutput("busy",      64'(busy),      64'(c <= done_cyc));
      if (exp_wv) begin
        checkOutput("waddr",       bus_waddr,          exp_addr);
        checkOutput("wstrb",       64'(bus_wstrb),     64'(exp_strb));
        checkOutput("wdata_lanes", bus_wdata & mask,   exp_data & mask);
      end
      if (c == done_cyc + 1) break;

      // Busy-time requests must be ignored; scramble them freely.
      req_valid  = 1'($urandom_range(0, 1));
      req_addr   = {$urandom, $urandom};
      req_funct3 = 3'($urandom_range(0, 7));
      req_wdata  = {$urandom, $urandom};
      if (c == done_cyc) req_valid = 1'b0;

      if (exp_wv) bus_wready = (c == 1 + wdelay);
      else        bus_wready = 1'($urandom_range(0, 1));

      if (!err && c >= wresp_start && c < done_cyc) begin
        bus_bvalid = (bdelay >= 0) && (c == wresp_start + bdelay);
        bus_bresp  = bresp;
      end else begin
        bus_bvalid = 1'($urandom_range(0, 1));
        bus_bresp  = 1'($urandom_range(0, 1));
      end
      @(negedge clk);
    end
    req_valid = 1'b0;
  endtask

  initial begin
    n_checks   = 0;
    n_fail     = 0;
    rst        = 1'b1;
    req_valid  = 1'b0;
    req_addr   = 64'h0;
    req_funct3 = 3'd0;
    req_wdata  = 64'h0;
    bus_wready = 1'b0;
    bus_bvalid = 1'b0;
    bus_bresp  = 1'b0;

    repeat (2) @(negedge clk);
    checkOutput("rst_req_ready",  64'(req_ready),  64'(1'b1));
    checkOutput("rst_wvalid",     64'(bus_wvalid), 64'(1'b0));
    checkOutput("rst_waddr",      bus_waddr,       64'h0);
    checkOutput("rst_wdata",      bus_wdata,       64'h0);
    checkOutput("rst_wstrb",      64'(bus_wstrb),  64'h0);
    checkOutput("rst_done_valid", 64'(done_valid), 64'(1'b0));
    checkOutput("rst_done_err",   64'(done_err),   64'(1'b0));
    checkOutput("rst_busy",       64'(busy),       64'(1'b0));
    rst = 1'b0;
    @(negedge clk);

    // SB into the top byte of a word, immediate handshakes.
    applyStimulus(64'h0000_0000_8000_0003, 3'b000, 64'h0123_4567_89AB_CDAB, 0, 0, 1'b0);
    // SD with wready held off for 5 cycles.
    applyStimulus(64'h0000_0000_8000_0010, 3'b011, 64'h1122_3344_5566_7788, 5, 0, 1'b0);
    // Misaligned SW and an undefined funct3.
    applyStimulus(64'h0000_0000_8000_0006, 3'b010, 64'hDEAD_BEEF_CAFE_F00D, 0, 0, 1'b0);
    applyStimulus(64'h0000_0000_8000_0000, 3'b100, 64'hDEAD_BEEF_CAFE_F00D, 0, 0, 1'b0);
    // SH with a bus error response.
    applyStimulus(64'h0000_0000_8000_0002, 3'b001, 64'h0000_0000_0000_BEEF, 0, 1, 1'b1);
    // Response timeout, then bvalid on the final allowed cycle.
    applyStimulus(64'h0000_0000_8000_0020, 3'b010, 64'h0000_0000_A5A5_5A5A, 1, -1, 1'b0);
    applyStimulus(64'h0000_0000_8000_0024, 3'b010, 64'h0000_0000_1234_5678, 0, TO - 1, 1'b0);
    applyStimulus(64'h0000_0000_8000_0028, 3'b011, 64'h0F0E_0D0C_0B0A_0908, 0, TO - 1, 1'b1);
    // One cycle too late counts as a timeout.
    applyStimulus(64'h0000_0000_8000_0030, 3'b000, 64'h0000_0000_0000_0077, 2, TO, 1'b0);

    // Reset asserted mid-WREQ clears the handshake without a clock edge.
    req_addr   = 64'h0000_0000_8000_0040;
    req_funct3 = 3'b011;
    req_wdata  = 64'hFFFF_0000_FFFF_0000;
    req_valid  = 1'b1;
    bus_wready = 1'b0;
    bus_bvalid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    checkOutput("pre_rst_wvalid", 64'(bus_wvalid), 64'(1'b1));
    #2 rst = 1'b1;
    #1;
    checkOutput("mid_rst_wvalid",    64'(bus_wvalid), 64'(1'b0));
    checkOutput("mid_rst_req_ready", 64'(req_ready),  64'(1'b1));
    checkOutput("mid_rst_busy",      64'(busy),       64'(1'b0));
    @(negedge clk);
    rst = 1'b0;
    applyStimulus(64'h0000_0000_8000_0045, 3'b000, 64'h0000_0000_0000_005C, 0, 0, 1'b0);

    // Randomized transactions, biased toward legal sizes and aligned addresses.
    for (int n = 0; n < 60; n++) begin
      logic [63:0] a;
      logic [2:0]  f;
      a = {32'h0000_0000, 32'h8000_0000 | ($urandom & 32'h0000_0FFF)};
      f = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(4, 7)) : 3'($urandom_range(0, 3));
      if ($urandom_range(0, 3) != 0) begin
        case (f)
          3'b001:  a[0]   = 1'b0;
          3'b010:  a[1:0] = 2'b00;
          3'b011:  a[2:0] = 3'b000;
          default: a      = a;
        endcase
      end
      applyStimulus(a, f, {$urandom, $urandom}, $urandom_range(0, 3),
                    $urandom_range(0, 6) - 1, 1'($urandom_range(0, 1)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
